da_if_mode_ctrl: RTL and testbench
==================================

# da_if_mode_ctrl

Mode controller that drives the digital-to-analog test interface (DA_test1..DA_test4) through power-on, normal, suspend and ATPG modes. It holds a software-programmed shadow of the normal-mode values and forces fixed safe values in ATPG and suspend. On suspend entry and exit it ramps the 4-bit DA_test4 trim one code at a time with a programmable settle interval. It sits between the register block and the analog macro, and its outputs are the signals the ADIF assertion checker samples in POR, ATPG and suspend.

## Interface
- SETTLE_CYC, 4: cycles per DA_test4 ramp step; legal range 1..255.
- T4_POR, 3: POR and shadow reset value of DA_test4.
- clk  in  1  block clock.
- rstb  in  1  reset; synchronous, active-low.
- atpg  in  1  ATPG mode request, level; synchronous to clk.
- susp  in  1  suspend request, level; synchronous to clk.
- cfg_wr  in  1  one-cycle write strobe for the shadow register.
- cfg_wdata  in  7  {test4[3:0], test3, test2, test1}.
- DA_test1  out  1  DA interface bit 1.
- DA_test2  out  1  DA interface bit 2.
- DA_test3  out  1  DA interface bit 3.
- DA_test4  out  4  DA interface trim code.
- susp_ack  out  1  high only in SUSPEND.
- busy  out  1  high in RAMP_DN or RAMP_UP.

## Operation
- States: NORMAL, RAMP_DN, SUSPEND, RAMP_UP, ATPG. All outputs are registered.
- Reset (rstb=0 at a clk edge, from any state, including mid-ramp):
  - State goes to NORMAL and the timer clears.
  - Shadow and outputs reset to test1=1, test2=0, test3=0, test4=T4_POR.
  - susp_ack=0, busy=0.
- Priority at each edge: rstb > atpg > susp. A cfg_wr updates the shadow in every state except under reset, in the same edge as any state change.
- NORMAL: outputs follow the shadow; a write becomes visible on the DA outputs one cycle after the cfg_wr edge.
- atpg=1 in any state: next state ATPG.
  - Outputs are 1,0,0,0 at once, with no ramp; any active ramp is aborted.
  - On atpg=0: go to SUSPEND if susp=1, otherwise RAMP_UP starting from test4=0.
- NORMAL with susp=1: enter RAMP_DN.
  - On the entry edge test2 and test3 go to 0 and test1 goes to 1; the timer clears.
- Timer: counts 0..SETTLE_CYC-1. At the edge where timer==SETTLE_CYC-1:
  - If test4 equals the target, take the terminal transition.
  - Otherwise step test4 by ±1 toward the target and clear the timer.
- RAMP_DN: target 0; terminal transition goes to SUSPEND.
- SUSPEND: outputs 1,0,0,0, susp_ack=1. On susp=0 go to RAMP_UP with the timer cleared.
- RAMP_UP: target is the live shadow test4, so a write mid-ramp retargets it and the ramp may step down.
  - test1..3 stay 1,0,0 during the ramp.
  - Terminal transition goes to NORMAL, loading test1..3 from the shadow.
- Reversal: susp=0 in RAMP_DN goes to RAMP_UP, and susp=1 in RAMP_UP goes to RAMP_DN. test4 keeps its current value and the timer clears.
- test4 never wraps: it is always stepped toward the target and is clamped to 0..15.

## Timing
- Suspend entry from test4=N takes (N+1)*SETTLE_CYC cycles from the RAMP_DN entry edge until susp_ack rises.
- Exit to target M takes (M+1)*SETTLE_CYC cycles from the RAMP_UP entry edge to NORMAL.
- Entering ATPG: outputs change on the first edge that samples atpg=1.
- busy is asserted on the edge that enters a ramp state and deasserted on the terminal edge.

## Test plan
- Reset with SETTLE_CYC=4, then hold rstb low 3 cycles.
  - Outputs must be 1,0,0,3; susp_ack=0, busy=0.
  - After release with atpg=susp=0, the state stays NORMAL with outputs unchanged.
- Suspend round trip from shadow {test4=3, test3=1, test2=1, test1=0}:
  - On entry, test2 and test3 drop to 0 and test1 goes to 1 at once.
  - test4 steps 3→2→1→0 at 4-cycle intervals; susp_ack rises 16 cycles after entry with outputs 1,0,0,0.
  - On susp=0, test4 steps 0→1→2→3 and the shadow values are restored after 16 cycles.
- Reversal: drop susp while test4=2 in RAMP_DN.
  - test4 must return to 3 after 4 cycles without reaching 1; susp_ack is never asserted.
- ATPG mid-ramp: assert atpg while test4=1 in RAMP_UP.
  - The next cycle shows 1,0,0,0 with busy=0.
  - Release atpg with susp=1: go to SUSPEND directly with susp_ack=1.
- Write in SUSPEND: cfg_wdata={test4=9,...} must not change outputs.
  - After susp=0, test4 ramps to 9, and the exit takes 40 cycles.
- Reset mid RAMP_DN at test4=2: the next edge gives outputs 1,0,0,3, the state is NORMAL, and the shadow is at POR values.

Source files
------------

// File: rtl/da_if_mode_ctrl.sv
// DA test interface mode controller: NORMAL / suspend ramp / ATPG sequencing
// of DA_test1..DA_test4. It keeps a software shadow of the normal-mode
// values and ramps the 4-bit trim one code per settle interval on suspend
// entry and exit.
//
// state     | meaning
// ----------+----------------------------------------------------------
// NORMAL    | DA outputs follow the shadow register
// RAMP_DN   | test4 stepping toward 0, test1..3 parked at 1,0,0
// SUSPEND   | outputs parked at 1,0,0,0, susp_ack high
// RAMP_UP   | test4 stepping toward the live shadow test4
// ATPG      | outputs forced to 1,0,0,0, no ramp
module da_if_mode_ctrl #(
  parameter int unsigned SETTLE_CYC = 4,
  parameter logic [3:0]  T4_POR     = 4'd3
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       atpg,
  input  logic       susp,
  input  logic       cfg_wr,
  input  logic [6:0] cfg_wdata,
  output logic       DA_test1,
  output logic       DA_test2,
  output logic       DA_test3,
  output logic [3:0] DA_test4,
  output logic       susp_ack,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_NORMAL,
    S_RAMP_DN,
    S_SUSPEND,
    S_RAMP_UP,
    S_ATPG
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [6:0] SHADOW_POR = {T4_POR, 1'b0, 1'b0, 1'b1};

  state_t     state, state_nxt;
  logic [7:0] timer, timer_nxt;
  logic [6:0] shadow, shadow_nxt;
  logic       t1_nxt, t2_nxt, t3_nxt;
  logic [3:0] t4_nxt;
  logic       ack_nxt, busy_nxt;
  logic       tc;

  // Register stage: state, timer, shadow and all outputs.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state    <= S_NORMAL;
      timer    <= '0;
      shadow   <= SHADOW_POR;
      DA_test1 <= 1'b1;
      DA_test2 <= 1'b0;
      DA_test3 <= 1'b0;
      DA_test4 <= T4_POR;
      susp_ack <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      shadow   <= shadow_nxt;
      DA_test1 <= t1_nxt;
      DA_test2 <= t2_nxt;
      DA_test3 <= t3_nxt;
      DA_test4 <= t4_nxt;
      susp_ack <= ack_nxt;
      busy     <= busy_nxt;
    end
  end

  // Next-state, timer and output decode; atpg overrides everything but reset.
  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    shadow_nxt = cfg_wr ? cfg_wdata : shadow;
    t1_nxt     = DA_test1;
    t2_nxt     = DA_test2;
    t3_nxt     = DA_test3;
    t4_nxt     = DA_test4;
    tc         = (timer == TIMER_LAST);

    if (atpg) begin
      state_nxt = S_ATPG;
      timer_nxt = '0;
      t1_nxt    = 1'b1;
      t2_nxt    = 1'b0;
      t3_nxt    = 1'b0;
      t4_nxt    = 4'd0;
    end else begin
      case (state)
        S_NORMAL: begin
          if (susp) begin
            state_nxt = S_RAMP_DN;
            timer_nxt = '0;
            t1_nxt    = 1'b1;
            t2_nxt    = 1'b0;
            t3_nxt    = 1'b0;
          end else begin
            t1_nxt = shadow[0];
            t2_nxt = shadow[1];
            t3_nxt = shadow[2];
            t4_nxt = shadow[6:3];
          end
        end
        S_RAMP_DN: begin
          if (!susp) begin
            state_nxt = S_RAMP_UP;
            timer_nxt = '0;
          end else if (tc) begin
            timer_nxt = '0;
            if (DA_test4 == 4'd0) state_nxt = S_SUSPEND;
            else                  t4_nxt    = DA_test4 - 4'd1;
          end else begin
            timer_nxt = timer + 8'd1;
          end
        end
        S_SUSPEND: begin
          t1_nxt = 1'b1;
          t2_nxt = 1'b0;
          t3_nxt = 1'b0;
          t4_nxt = 4'd0;
          if (!susp) begin
            state_nxt = S_RAMP_UP;
            timer_nxt = '0;
          end
        end
        S_RAMP_UP: begin
          if (susp) begin
            state_nxt = S_RAMP_DN;
            timer_nxt = '0;
          end else if (tc) begin
            timer_nxt = '0;
            if (DA_test4 == shadow[6:3]) begin
              state_nxt = S_NORMAL;
              t1_nxt    = shadow[0];
              t2_nxt    = shadow[1];
              t3_nxt    = shadow[2];
            end else if (DA_test4 < shadow[6:3]) begin
              t4_nxt = DA_test4 + 4'd1;
            end else begin
              t4_nxt = DA_test4 - 4'd1;
            end
          end else begin
            timer_nxt = timer + 8'd1;
          end
        end
        S_ATPG: begin
          timer_nxt = '0;
          t4_nxt    = 4'd0;
          state_nxt = susp ? S_SUSPEND : S_RAMP_UP;
        end
        default: begin
          state_nxt = S_NORMAL;
          timer_nxt = '0;
        end
      endcase
    end

    ack_nxt  = (state_nxt == S_SUSPEND);
    busy_nxt = (state_nxt == S_RAMP_DN) || (state_nxt == S_RAMP_UP);
  end

endmodule

// File: tb/tb_da_if_mode_ctrl.sv
// Directed bench for da_if_mode_ctrl with SETTLE_CYC=4, T4_POR=3.
module tb_da_if_mode_ctrl;

  logic       clk = 1'b0;
  logic       rstb, atpg, susp, cfg_wr;
  logic [6:0] cfg_wdata;
  logic       DA_test1, DA_test2, DA_test3;
  logic [3:0] DA_test4;
  logic       susp_ack, busy;

  int vectors = 0;
  int miscompares = 0;

  da_if_mode_ctrl #(.SETTLE_CYC(4), .T4_POR(4'd3)) dut (
    .clk(clk), .rstb(rstb), .atpg(atpg), .susp(susp),
    .cfg_wr(cfg_wr), .cfg_wdata(cfg_wdata),
    .DA_test1(DA_test1), .DA_test2(DA_test2), .DA_test3(DA_test3),
    .DA_test4(DA_test4), .susp_ack(susp_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  // expected word {susp_ack, busy, test4, test3, test2, test1}
  function automatic logic [8:0] v(input logic ack, input logic bsy,
                                   input logic [3:0] t4, input logic t3,
                                   input logic t2, input logic t1);
    return {ack, bsy, t4, t3, t2, t1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {susp_ack, busy, DA_test4, DA_test3, DA_test2, DA_test1};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rstb = 1'b0; atpg = 1'b0; susp = 1'b0; cfg_wr = 1'b0; cfg_wdata = '0;

    // reset held for 3 cycles
    tick(); tick(); tick();
    chk("reset", v(0, 0, 4'd3, 0, 0, 1));
    rstb = 1'b1;
    tick(); tick(); tick();
    chk("post_reset_normal", v(0, 0, 4'd3, 0, 0, 1));

    // program shadow {test4=3, test3=1, test2=1, test1=0}
    cfg_wdata = {4'd3, 1'b1, 1'b1, 1'b0};
    cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    chk("write_not_yet_visible", v(0, 0, 4'd3, 0, 0, 1));
    tick();
    chk("write_visible", v(0, 0, 4'd3, 1, 1, 0));

    // suspend entry: 16 cycles from entry edge to susp_ack
    susp = 1'b1;
    tick();
    chk("rdn_entry", v(0, 1, 4'd3, 0, 0, 1));
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i < 16) chk("rdn_step", v(0, 1, 4'(3 - i / 4), 0, 0, 1));
      else        chk("suspend_reached", v(1, 0, 4'd0, 0, 0, 1));
    end

    // suspend exit: 16 cycles back to NORMAL with shadow restored
    susp = 1'b0;
    tick();
    chk("rup_entry", v(0, 1, 4'd0, 0, 0, 1));
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i < 16) chk("rup_step", v(0, 1, 4'(i / 4), 0, 0, 1));
      else        chk("normal_restored", v(0, 0, 4'd3, 1, 1, 0));
    end

    // reversal at test4=2 in RAMP_DN
    susp = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) tick();
    chk("rev_at_2", v(0, 1, 4'd2, 0, 0, 1));
    susp = 1'b0;
    tick();
    chk("rev_entry", v(0, 1, 4'd2, 0, 0, 1));
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i < 4)       chk("rev_hold_2", v(0, 1, 4'd2, 0, 0, 1));
      else if (i < 8)  chk("rev_back_3", v(0, 1, 4'd3, 0, 0, 1));
      else             chk("rev_normal", v(0, 0, 4'd3, 1, 1, 0));
    end

    // ATPG mid RAMP_UP at test4=1
    susp = 1'b1;
    tick();
    for (int i = 1; i <= 16; i++) tick();
    chk("atpg_pre_suspend", v(1, 0, 4'd0, 0, 0, 1));
    susp = 1'b0;
    tick();
    for (int i = 1; i <= 4; i++) tick();
    chk("atpg_pre_rup_1", v(0, 1, 4'd1, 0, 0, 1));
    atpg = 1'b1;
    tick();
    chk("atpg_force", v(0, 0, 4'd0, 0, 0, 1));
    susp = 1'b1;
    tick();
    chk("atpg_hold", v(0, 0, 4'd0, 0, 0, 1));
    atpg = 1'b0;
    tick();
    chk("atpg_to_suspend", v(1, 0, 4'd0, 0, 0, 1));

    // write in SUSPEND must not disturb outputs
    cfg_wdata = {4'd9, 1'b0, 1'b1, 1'b1};
    cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    chk("susp_write_1", v(1, 0, 4'd0, 0, 0, 1));
    tick();
    chk("susp_write_2", v(1, 0, 4'd0, 0, 0, 1));
    susp = 1'b0;
    tick();
    chk("rup9_entry", v(0, 1, 4'd0, 0, 0, 1));
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 20)      chk("rup9_mid", v(0, 1, 4'd5, 0, 0, 1));
      else if (i == 39) chk("rup9_last", v(0, 1, 4'd9, 0, 0, 1));
      else if (i == 40) chk("rup9_normal", v(0, 0, 4'd9, 0, 1, 1));
    end

    // reset mid RAMP_DN at test4=2
    susp = 1'b1;
    tick();
    for (int i = 1; i <= 28; i++) tick();
    chk("rdn9_at_2", v(0, 1, 4'd2, 0, 0, 1));
    rstb = 1'b0;
    tick();
    chk("reset_mid_ramp", v(0, 0, 4'd3, 0, 0, 1));
    rstb = 1'b1;
    susp = 1'b0;
    tick();
    tick();
    chk("shadow_por_after_reset", v(0, 0, 4'd3, 0, 0, 1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
